// File: rtl/mini_fsm_pkg.sv
// Shared types and default parameters for the mini_fsm start-strobe generator.
package mini_fsm_pkg;

    localparam int REG_W_DEF    = 8;
    localparam int TRIG_BIT_DEF = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FIRE = 1'b1
    } state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector on one bit of a register bus; history resets high so a
// bit already set when reset releases is not treated as a new rise.
module rise_edge_det #(
    parameter int REG_W    = 8,
    parameter int TRIG_BIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] reg_in,
    output logic             rise
);

    logic bit_s;
    logic prev_r;
    logic unused_bits_s;

    assign bit_s = reg_in[TRIG_BIT];

    // Only the trigger bit matters; the remaining bits are folded into a dead net.
    assign unused_bits_s = ^reg_in;

    // Previous-sample register for the trigger bit
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= bit_s;
        end
    end

    assign rise = bit_s & ~prev_r;

endmodule

// File: rtl/mini_fsm.sv
// Turns a 0->1 transition of a control-register bit into a single-cycle,
// registered start strobe.
module mini_fsm
    import mini_fsm_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int TRIG_BIT = TRIG_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] reg_in,
    output logic             start_pulse
);

    state_t state_r;
    state_t state_next_s;
    logic   rise_s;

    rise_edge_det #(
        .REG_W    (REG_W),
        .TRIG_BIT (TRIG_BIT)
    ) u_rise_edge_det (
        .clk    (clk),
        .rst    (rst),
        .reg_in (reg_in),
        .rise   (rise_s)
    );

    // Next-state logic; FIRE always lasts exactly one cycle
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_next_s = FIRE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FIRE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register; the strobe is a registered copy of (state == FIRE)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            start_pulse <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            start_pulse <= (state_next_s == FIRE);
        end
    end

endmodule

// File: tb/tb_mini_fsm.sv
// Self-checking bench for mini_fsm: directed scenarios plus random stimulus,
// checked against a sample-history model of the rise rule.
module tb_mini_fsm;

    localparam int REG_W    = 8;
    localparam int TRIG_BIT = 0;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] reg_in;
    logic             start_pulse;

    int checks   = 0;
    int failures = 0;

    // Last two trigger-bit samples; a reset edge counts as "seen high".
    logic hist[$];

    mini_fsm #(
        .REG_W    (REG_W),
        .TRIG_BIT (TRIG_BIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_in      (reg_in),
        .start_pulse (start_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [REG_W-1:0] mk(input logic b);
        logic [REG_W-1:0] v;
        v = REG_W'($urandom);
        v[TRIG_BIT] = b;
        return v;
    endfunction

    // Drive one cycle on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic [REG_W-1:0] v,
                        output logic obs, output logic exp);
        @(negedge clk);
        rst    = r;
        reg_in = v;
        @(posedge clk);
        if (r) hist.push_back(1'b1);
        else   hist.push_back(v[TRIG_BIT]);
        if (hist.size() > 2) void'(hist.pop_front());
        exp = (!r && hist.size() == 2 && hist[1] == 1'b1 && hist[0] == 1'b0);
        #1;
        obs = start_pulse;
    endtask

    task automatic test_reset();
        logic obs, exp;
        for (int i = 0; i < 4; i++) begin
            step((i < 2) ? 1'b1 : 1'b0, 8'h00, obs, exp);
            checks++;
            if (obs !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc%0d: start_pulse=%b expected=0", i, obs);
            end
        end
    endtask

    task automatic test_single_rise(inout int total);
        logic obs, exp;
        int   pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, mk(1'b1), obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL single_rise cyc%0d: start_pulse=%b expected=%b", i, obs, exp);
            end
            if (obs === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL single_rise_count: pulses=%0d expected=1", pulses);
        end
        total += pulses;
    endtask

    task automatic test_retrigger(inout int total);
        logic obs, exp;
        logic seq [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, mk(seq[i]), obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL retrigger cyc%0d: start_pulse=%b expected=%b", i, obs, exp);
            end
            if (obs === 1'b1) pulses++;
        end
        total += pulses;
        checks++;
        if (total !== 3) begin
            failures++;
            $display("FAIL retrigger_total: pulses=%0d expected=3", total);
        end
    endtask

    task automatic test_level_held();
        logic obs, exp;
        int   pulses = 0;
        step(1'b0, mk(1'b0), obs, exp);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, mk(1'b1), obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL level_held cyc%0d: start_pulse=%b expected=%b", i, obs, exp);
            end
            if (obs === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL level_held_count: pulses=%0d expected=1", pulses);
        end
    endtask

    task automatic test_other_bits();
        logic obs, exp;
        int   pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i % 2 == 0) ? 8'hFE : 8'h00, obs, exp);
            checks++;
            if (obs !== 1'b0) begin
                failures++;
                $display("FAIL other_bits cyc%0d: start_pulse=%b expected=0", i, obs);
            end
            if (obs === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL other_bits_count: pulses=%0d expected=0", pulses);
        end
    endtask

    task automatic test_high_at_reset();
        logic obs, exp;
        int   pulses = 0;
        logic r_seq [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic b_seq [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic want  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(r_seq[i], mk(b_seq[i]), obs, exp);
            checks++;
            if (obs !== want[i] || obs !== exp) begin
                failures++;
                $display("FAIL high_at_reset cyc%0d: start_pulse=%b expected=%b", i, obs, want[i]);
            end
            if (obs === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL high_at_reset_count: pulses=%0d expected=1", pulses);
        end
    endtask

    task automatic test_fast_toggle();
        logic obs, exp;
        int   pulses = 0;
        step(1'b0, mk(1'b0), obs, exp);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, mk((i % 2 == 0) ? 1'b1 : 1'b0), obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL fast_toggle cyc%0d: start_pulse=%b expected=%b", i, obs, exp);
            end
            if (obs === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 5) begin
            failures++;
            $display("FAIL fast_toggle_count: pulses=%0d expected=5", pulses);
        end
    endtask

    task automatic test_reset_abort();
        logic obs, exp;
        logic r_seq [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic b_seq [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic want  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            step(r_seq[i], mk(b_seq[i]), obs, exp);
            checks++;
            if (obs !== want[i] || obs !== exp) begin
                failures++;
                $display("FAIL reset_abort cyc%0d: start_pulse=%b expected=%b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic obs, exp;
        logic r, b;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(15, 0) == 0);
            b = $urandom_range(1, 0) != 0;
            step(r, mk(b), obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random cyc%0d: start_pulse=%b expected=%b rst=%b", i, obs, exp, r);
            end
        end
    endtask

    initial begin
        int total;
        total  = 0;
        rst    = 1'b1;
        reg_in = 8'h00;
        test_reset();
        test_single_rise(total);
        test_retrigger(total);
        test_level_held();
        test_other_bits();
        test_high_at_reset();
        test_fast_toggle();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
